// File: rtl/imul_var_lat_param.sv
// Iterative integer multiplier with val/rdy request and response interfaces.
// Supports MUL, MULH, MULHSU and MULHU. Latency varies with the multiplier:
// runs of zero bits are skipped (up to MAX_SKIP per cycle), and the operation
// ends as soon as the remaining multiplier is zero.
//
// Ports:
//   clk       clock, all state on posedge
//   reset     synchronous active-high reset
//   req_val   request valid
//   req_rdy   request ready (high only in IDLE, low during reset)
//   req_msg   {op[1:0], a[NBITS-1:0], b[NBITS-1:0]}
//   resp_val  response valid (high only in DONE, low during reset)
//   resp_rdy  response ready
//   resp_msg  selected product half, zero outside DONE
module imul_var_lat_param #(
  parameter int unsigned NBITS    = 32,
  parameter int unsigned MAX_SKIP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2*NBITS+1:0] req_msg,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [NBITS-1:0]   resp_msg
);

  localparam int unsigned W2  = 2 * NBITS;
  localparam int unsigned SkW = $clog2(MAX_SKIP + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [W2-1:0]     areg_q, areg_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [NBITS-1:0]  breg_q, breg_d;
  logic              neg_q, neg_d;
  logic [1:0]        op_q, op_d;

  logic [1:0]        op_in;
  logic [NBITS-1:0]  a_in, b_in, a_abs, b_abs;
  logic              a_neg, b_neg;
  logic [SkW-1:0]    skip;
  logic [W2-1:0]     prod;

  assign op_in = req_msg[W2+1:W2];
  assign a_in  = req_msg[W2-1:NBITS];
  assign b_in  = req_msg[NBITS-1:0];

  // a is signed for MULH/MULHSU, b only for MULH. MUL is treated as unsigned:
  // the low half is the same either way and |b| keeps its full bit pattern.
  assign a_neg = ((op_in == 2'b01) || (op_in == 2'b10)) && a_in[NBITS-1];
  assign b_neg = (op_in == 2'b01) && b_in[NBITS-1];
  // Negating the most negative value yields 2^(NBITS-1), exact as unsigned.
  assign a_abs = a_neg ? -a_in : a_in;
  assign b_abs = b_neg ? -b_in : b_in;

  // Trailing-zero count of breg, saturated at MAX_SKIP.
  always_comb begin
    skip = SkW'(MAX_SKIP);
    for (int i = int'(MAX_SKIP) - 1; i >= 0; i--) begin
      if (breg_q[i]) skip = SkW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    acc_d   = acc_q;
    breg_d  = breg_q;
    neg_d   = neg_q;
    op_d    = op_q;
    case (state_q)
      StIdle: begin
        if (req_val) begin
          areg_d  = {{NBITS{1'b0}}, a_abs};
          breg_d  = b_abs;
          acc_d   = '0;
          neg_d   = a_neg ^ b_neg;
          op_d    = op_in;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (breg_q == '0) begin
          state_d = StDone;
        end else if (breg_q[0]) begin
          acc_d  = acc_q + areg_q;
          areg_d = areg_q << 1;
          breg_d = breg_q >> 1;
        end else begin
          areg_d = areg_q << skip;
          breg_d = breg_q >> skip;
        end
      end
      StDone: begin
        if (resp_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      areg_q  <= '0;
      acc_q   <= '0;
      breg_q  <= '0;
      neg_q   <= 1'b0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      acc_q   <= acc_d;
      breg_q  <= breg_d;
      neg_q   <= neg_d;
      op_q    <= op_d;
    end
  end

  // Handshake outputs come from the state register; reset only masks them.
  assign req_rdy  = (state_q == StIdle) && !reset;
  assign resp_val = (state_q == StDone) && !reset;

  assign prod = neg_q ? -acc_q : acc_q;

  // Forced to zero outside DONE so partial sums never appear on the bus.
  always_comb begin
    resp_msg = '0;
    if (state_q == StDone) begin
      resp_msg = (op_q == 2'b00) ? prod[NBITS-1:0] : prod[W2-1:NBITS];
    end
  end

endmodule

// File: tb/tb_imul_var_lat_param.sv
// Scoreboard bench for imul_var_lat_param (NBITS=32, MAX_SKIP=4). The driver
// pushes the expected result, latency and sink stall per request; a monitor
// pops and compares whenever a response appears and checks hold behaviour.
module tb_imul_var_lat_param;

  localparam int unsigned NBITS = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               req_val = 1'b0;
  logic               req_rdy;
  logic [2*NBITS+1:0] req_msg = '0;
  logic               resp_val;
  logic               resp_rdy = 1'b0;
  logic [NBITS-1:0]   resp_msg;

  imul_var_lat_param #(.NBITS(NBITS), .MAX_SKIP(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] msg;
    int          lat;      // -1: not checked
    int          acc_cyc;
    int          stall;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   in_resp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [65:0] aa, bb, p;
    aa = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
    bb = (op == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = aa * bb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat, input int stall,
                      input bit push);
    exp_t e;
    int   n;
    req_val = 1'b1;
    req_msg = {op, a, b};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_rdy && n < 300);
    if (!req_rdy) begin
      checks++;
      errors++;
      $display("FAIL req_rdy_timeout: got 0, expected 1 within 300 cycles");
      req_val = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      if (push) begin
        e.msg = exp; e.lat = lat; e.acc_cyc = cyc; e.stall = stall;
        sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      req_val = 1'b0;
      req_msg = '0;
    end
  endtask

  // Monitor / sink
  initial begin : monitor
    exp_t        e;
    logic [31:0] held;
    int          stall;
    stall = 0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_resp  = 1'b0;
        resp_rdy = 1'b0;
      end else if (resp_val) begin
        chk("req_rdy_in_done", req_rdy, 0);
        if (!in_resp) begin
          in_resp = 1'b1;
          held    = resp_msg;
          stall   = 0;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_msg 0x%0h, expected no response", resp_msg);
          end else begin
            e = sb_q.pop_front();
            chk("resp_msg", resp_msg, e.msg);
            if (e.lat >= 0) chk("latency", cyc - e.acc_cyc, e.lat);
            stall = e.stall;
          end
        end else begin
          chk("resp_msg_hold", resp_msg, held);
        end
        if (stall > 0) begin
          resp_rdy = 1'b0;
          stall--;
        end else begin
          resp_rdy = 1'b1;
          in_resp  = 1'b0;
        end
      end else begin
        if (in_resp) begin
          checks++;
          errors++;
          $display("FAIL resp_val_hold: got 0, expected 1 while stalled");
          in_resp = 1'b0;
        end
        resp_rdy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [1:0]  op;
    logic [31:0] a, b;
    int          n;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_rdy", req_rdy, 0);
    chk("reset_resp_val", resp_val, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_req_rdy", req_rdy, 1);
    chk("post_reset_resp_val", resp_val, 0);
    chk("post_reset_resp_msg", resp_msg, 0);
    @(posedge clk);
    #1;

    // Directed vectors
    send(2'b00, 32'd3, 32'd4, 32'h0000000C, 4, 0, 1);
    send(2'b00, 32'h12345678, 32'd0, 32'h00000000, 2, 0, 1);
    send(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, -1, 0, 1);
    send(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, -1, 0, 1);
    send(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, -1, 0, 1);
    send(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0, 1);
    send(2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, -1, 0, 1);
    send(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, -1, 0, 1);
    send(2'b01, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, -1, 0, 1);

    // Back-pressure: sink holds off 5 cycles
    send(2'b00, 32'd3, 32'd4, 32'h0000000C, 4, 5, 1);

    // Random stream with random sink delays
    for (int i = 0; i < 50; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      if (i % 10 == 3) a = 32'h80000000;
      if (i % 10 == 7) b = 32'h80000000;
      send(op, a, b, model(op, a, b), -1, $urandom_range(0, 3), 1);
    end

    // Wait for the stream to drain before the reset test
    n = 0;
    while ((sb_q.size() != 0 || in_resp || !req_rdy) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;

    // Reset mid-CALC abandons the operation
    send(2'b00, 32'd7, 32'h0000FFFF, 32'd0, -1, 0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midcalc_reset_req_rdy", req_rdy, 0);
    chk("midcalc_reset_resp_val", resp_val, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("after_reset_req_rdy", req_rdy, 1);
    chk("after_reset_resp_msg", resp_msg, 0);
    repeat (30) @(posedge clk);
    #1;
    send(2'b00, 32'd6, 32'd7, 32'h0000002A, -1, 0, 1);

    n = 0;
    while ((sb_q.size() != 0 || in_resp) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0 || in_resp) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
